apb_mem_slave: RTL
==================

APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data bus width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning paddr width in bits.
REQ-003 SHALL have parameter DEPTH, default 16, meaning number of DATA_W-bit memory words; legal range 2..4096.
REQ-004 SHALL have parameter WAIT, default 0, meaning access-phase wait states inserted before pready; legal range 0..15.
REQ-005 SHALL use one clock and a synchronous, active-low reset: pclk is the only clock and presetn is the reset.
REQ-006 SHALL have port pclk, input, 1 bit, rising-edge clock.
REQ-007 SHALL have port presetn, input, 1 bit, synchronous active-low reset.
REQ-008 SHALL have port psel, input, 1 bit, slave select.
REQ-009 SHALL have port penable, input, 1 bit, access-phase indicator.
REQ-010 SHALL have port pwrite, input, 1 bit, 1 = write, 0 = read.
REQ-011 SHALL have port paddr, input, ADDR_W bits, byte address.
REQ-012 SHALL have port pwdata, input, DATA_W bits, write data.
REQ-013 SHALL have port pstrb, input, DATA_W/8 bits, byte-lane write strobes; the port exists only when APB_MEM_STRB_EN is defined.
REQ-014 SHALL have port prdata, output, DATA_W bits, registered read data.
REQ-015 SHALL have port pready, output, 1 bit, transfer-complete indicator.
REQ-016 SHALL have port pslverr, output, 1 bit, error response; valid only while pready = 1.

Function
REQ-017 SHALL implement FSM states IDLE and ACCESS.
REQ-018 SHALL, in IDLE with psel=1 and penable=0 (setup), capture paddr, pwrite, pwdata and pstrb, load wait counter wcnt=WAIT, compute err_q, and go to ACCESS at the next edge.
REQ-019 SHALL compute word index as paddr >> log2(DATA_W/8).
REQ-020 SHALL set err_q=1 if the index is >= DEPTH or the paddr low log2(DATA_W/8) bits are nonzero (misaligned).
REQ-021 SHALL, on a setup read with err_q=0, load prdata from mem[index] at the setup edge; on a read with err_q=1, load prdata with 0.
REQ-022 SHALL, in ACCESS with psel=1 and penable=1 and wcnt!=0, decrement wcnt each cycle with pready=0.
REQ-023 SHALL drive pready=1 combinationally while in ACCESS with psel=1, penable=1 and wcnt=0, giving WAIT+1 access-phase cycles.
REQ-024 SHALL drive pslverr=err_q while pready=1, and 0 otherwise.
REQ-025 SHALL, on a write whose pready cycle has err_q=0, commit captured data to mem[index] at that edge; a write with err_q=1 SHALL leave memory unchanged.
REQ-026 SHALL return to IDLE at the pready edge; back-to-back transfers (setup on the next cycle) SHALL be supported with no idle cycle.
REQ-027 SHALL, when psel=0 or penable=0 in ACCESS before completion, abort: return to IDLE with no memory write and no pready.
REQ-028 SHALL ignore changes to paddr, pwdata and pwrite during ACCESS (captured values are used).
REQ-029 SHALL ignore psel=1 with penable=1 seen in IDLE (no setup phase), leaving pready=0.
REQ-030 SHALL hold prdata stable between transfers; writes SHALL NOT alter prdata.

Reset
REQ-031 SHALL, on presetn=0 at a pclk edge, force state=IDLE, wcnt=0, prdata=0, pready=0, pslverr=0 and err_q=0.
REQ-032 SHALL not write memory during reset, including a reset asserted mid-ACCESS; memory contents are not cleared by reset.

Configuration
REQ-033 SHALL, with APB_MEM_STRB_EN defined, write only lanes where pstrb[i]=1 and force err_q=1 for reads with pstrb!=0; without the macro, the pstrb port is absent and writes update all lanes.

Verification (DATA_W=32, DEPTH=16, WAIT=2)
REQ-034 SHALL cover: write 0xA5A51234 @0x0C, then read @0x0C -> pready high on 3rd access cycle each time, prdata=0xA5A51234, pslverr=0.
REQ-035 SHALL cover: write 0xDEADBEEF @0x40, then read @0x40 -> pslverr=1 both, read prdata=0x00000000, all 16 words unchanged.
REQ-036 SHALL cover: read @0x05 (misaligned) -> pslverr=1, prdata=0.
REQ-037 SHALL cover (STRB_EN): write 0xFFFFFFFF @0x00, then write 0x11223344 with pstrb=0b0101, then read @0x00 -> prdata=0xFF22FF44.
REQ-038 SHALL cover: write 0x55 @0x08 with presetn=0 in the 2nd access cycle -> pready=0, prdata=0, then read @0x08 returns the prior value.
REQ-039 SHALL cover: penable dropped during wait on write @0x04 -> no pready, memory unchanged, next setup accepted from IDLE.

Source files
------------

// File: rtl/apb_mem_slave.sv
// APB3 memory-mapped slave: DEPTH words of DATA_W bits with WAIT access-phase wait states.
// Define APB_MEM_STRB_EN to add the pstrb port and byte-lane writes.
module apb_mem_slave #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16,
  parameter int WAIT   = 0
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
`ifdef APB_MEM_STRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q, state_d;
  logic [3:0]          wcnt_q;
  logic                err_q;
  logic                write_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   word_idx;
  logic                misaligned;
  logic                out_of_range;
  logic                rd_strb_err;
  logic                setup_err;
  logic [STRB_W-1:0]   strb_in;
  logic                setup;
  logic                access_on;
  logic                mem_we;

`ifdef APB_MEM_STRB_EN
  assign strb_in     = pstrb;
  assign rd_strb_err = (pstrb != '0);
`else
  assign strb_in     = '1;
  assign rd_strb_err = 1'b0;
`endif

  // Address decode happens at the setup phase; the result is held in err_q for the access phase.
  assign word_idx     = paddr >> OFF_W;
  assign misaligned   = (paddr & ADDR_W'(STRB_W - 1)) != '0;
  assign out_of_range = word_idx >= ADDR_W'(DEPTH);
  assign setup_err    = out_of_range | misaligned | (!pwrite & rd_strb_err);

  assign setup     = (state_q == IDLE) && psel && !penable;
  assign access_on = (state_q == ACCESS) && psel && penable;

  assign pready  = access_on && (wcnt_q == 4'd0) && presetn;
  assign pslverr = pready && err_q;
  assign mem_we  = pready && write_q && !err_q;

  always_ff @(posedge pclk) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (setup) state_d = ACCESS;
      // Leaving the access phase early (psel or penable dropped) is an abort.
      ACCESS: if (!access_on || (wcnt_q == 4'd0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      wcnt_q  <= 4'd0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      prdata  <= '0;
    end else if (setup) begin
      wcnt_q  <= 4'(WAIT);
      err_q   <= setup_err;
      write_q <= pwrite;
      idx_q   <= word_idx[IDX_W-1:0];
      wdata_q <= pwdata;
      strb_q  <= strb_in;
      if (!pwrite) prdata <= setup_err ? '0 : mem[word_idx[IDX_W-1:0]];
    end else if (access_on && (wcnt_q != 4'd0)) begin
      wcnt_q <= wcnt_q - 4'd1;
    end
  end

  // Storage is not reset; pready already carries presetn so reset never writes.
  always_ff @(posedge pclk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (strb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
